serial_mag_compare_ctrl: RTL and testbench

- Multi-cycle magnitude comparator controller for wide operands.
- Shares a single 4-bit compare slice across all nibbles of a WIDTH-bit operand pair, one nibble per clock, MSB nibble first.
- Terminates early on the first differing nibble.
- Sits beside the 4/8-bit cascade comparators as the area-cheap option for 16/32/64-bit compares, with a start/done handshake toward the issuing logic.

---
 rtl/serial_cmp_pkg.sv | 27 ++
 rtl/nibble_cmp.sv | 15 +
 rtl/serial_mag_compare_ctrl.sv | 118 +++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types, sizing helpers and result encodings for the serial
// nibble-wise magnitude comparator.
package serial_cmp_pkg;

  // Controller states: waiting for a request, or walking nibbles MSB-first.
  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Result encodings, laid out as {agtb, aeqb, altb} so exactly one bit is set.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Number of 4-bit nibbles in an operand of the given width.
  function automatic int nib_of(input int width);
    return width / 4;
  endfunction

  // Width of a counter that can hold 0..nib_of(width) inclusive.
  function automatic int cw_of(input int width);
    return $clog2(nib_of(width) + 1);
  endfunction

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit unsigned magnitude slice. No cascade inputs: the
// controller supplies ordering by presenting nibbles MSB-first.
module nibble_cmp (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a_i >  b_i);
  assign eq = (a_i == b_i);
  assign lt = (a_i <  b_i);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Multi-cycle unsigned magnitude comparator. One shared 4-bit slice examines
// one nibble per clock, most significant first, and stops on the first
// differing nibble. start/done handshake; flags hold until the next result.
module serial_mag_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NIB   = nib_of(WIDTH),
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  output logic [CW-1:0]    nib_used
);

  localparam int IW = $clog2(NIB);

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       flags_q;
  logic [CW-1:0]    nib_used_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             slice_gt;
  logic             slice_eq;
  logic             slice_lt;

  // Select the nibble currently under examination from the captured operands.
  assign nib_a = ra_q[{idx_q, 2'b00} +: 4];
  assign nib_b = rb_q[{idx_q, 2'b00} +: 4];

  nibble_cmp u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .gt  (slice_gt),
    .eq  (slice_eq),
    .lt  (slice_lt)
  );

  // Controller FSM with registered handshake, result flags and nibble count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      // NOTE: the operand copies are plain flops, not a memory, so they are
      // cleared with everything else and never expose stale data after reset.
      ra_q       <= '0;
      rb_q       <= '0;
      idx_q      <= IW'(NIB - 1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flags_q    <= RES_NONE;
      nib_used_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            idx_q   <= IW'(NIB - 1);
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!slice_eq) begin
            // First differing nibble decides the ordering outright.
            flags_q    <= slice_gt ? RES_GT : RES_LT;
            nib_used_q <= CW'(NIB) - CW'(idx_q);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (idx_q == '0) begin
            // Every nibble matched down to the LSB.
            flags_q    <= RES_EQ;
            nib_used_q <= CW'(NIB);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign agtb     = flags_q[2];
  assign aeqb     = flags_q[1];
  assign altb     = flags_q[0];
  assign nib_used = nib_used_q;

  // slice_lt is implied by !gt && !eq; kept on the slice for completeness.
  logic unused_lt;
  assign unused_lt = slice_lt;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed and randomised bench for serial_mag_compare_ctrl at WIDTH=32.
module tb_serial_mag_compare_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic              agtb;
  logic              aeqb;
  logic              altb;
  logic [CW-1:0]     nib_used;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .agtb     (agtb),
    .aeqb     (aeqb),
    .altb     (altb),
    .nib_used (nib_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; lat = edges after accept.
  task automatic do_compare(input logic [31:0] av, input logic [31:0] bv,
                            output int lat, output logic busy_acc);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    busy_acc = busy;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_handshake: busy/done=%b expected 00", {busy, done});
    end
    tests_run++;
    if ({agtb, aeqb, altb} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000", {agtb, aeqb, altb});
    end
    tests_run++;
    if (nib_used !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_nib_used: got %0d expected 0", nib_used);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_early_exit();
    int   lat;
    logic bacc;
    do_compare(32'h8000_0000, 32'h7FFF_FFFF, lat, bacc);
    tests_run++;
    if (bacc !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_busy: busy after accept %b expected 1", bacc);
    end
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL early_latency: got %0d expected 1", lat);
    end
    tests_run++;
    if ({agtb, aeqb, altb, nib_used} !== {3'b100, 4'd1}) begin
      tests_failed++;
      $display("FAIL early_result: flags=%b nib=%0d expected 100 nib=1",
               {agtb, aeqb, altb}, nib_used);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_busy_drop: busy=%b expected 0 at done", busy);
    end
  endtask

  task automatic test_late_diff();
    int   lat;
    logic bacc;
    do_compare(32'h1234_5678, 32'h1234_5679, lat, bacc);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL late_latency: got %0d expected 8", lat);
    end
    tests_run++;
    if ({agtb, aeqb, altb, nib_used} !== {3'b001, 4'd8}) begin
      tests_failed++;
      $display("FAIL late_result: flags=%b nib=%0d expected 001 nib=8",
               {agtb, aeqb, altb}, nib_used);
    end
    step();
  endtask

  task automatic test_equal();
    int   lat;
    logic bacc;
    do_compare(32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, bacc);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL equal_latency: got %0d expected 8", lat);
    end
    tests_run++;
    if ({agtb, aeqb, altb, nib_used} !== {3'b010, 4'd8}) begin
      tests_failed++;
      $display("FAIL equal_result: flags=%b nib=%0d expected 010 nib=8",
               {agtb, aeqb, altb}, nib_used);
    end
    step();
    tests_run++;
    if ({done, agtb, aeqb, altb} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL equal_hold: done/flags=%b expected 0010",
               {done, agtb, aeqb, altb});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra_done;
    a = 32'h0000_0F00;
    b = 32'h0000_0E00;
    start = 1'b1;
    step();
    // Hold a new request during busy; it must be ignored, then accepted on done.
    a = 32'h0000_0000;
    b = 32'h0000_0001;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (lat !== 6) begin
      tests_failed++;
      $display("FAIL b2b_first_latency: got %0d expected 6", lat);
    end
    tests_run++;
    if ({agtb, aeqb, altb, nib_used} !== {3'b100, 4'd6}) begin
      tests_failed++;
      $display("FAIL b2b_first_result: flags=%b nib=%0d expected 100 nib=6",
               {agtb, aeqb, altb}, nib_used);
    end
    // start still high on the done cycle: this edge accepts the second request.
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy/done=%b expected 10", {busy, done});
    end
    lat = -1;
    extra_done = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL b2b_second_latency: got %0d expected 8", lat);
    end
    tests_run++;
    if ({agtb, aeqb, altb, nib_used} !== {3'b001, 4'd8}) begin
      tests_failed++;
      $display("FAIL b2b_second_result: flags=%b nib=%0d expected 001 nib=8",
               {agtb, aeqb, altb}, nib_used);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) extra_done++;
    end
    tests_run++;
    if (extra_done !== 0) begin
      tests_failed++;
      $display("FAIL b2b_no_extra_done: got %0d pulses expected 0", extra_done);
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    int   stray;
    logic bacc;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    tests_run++;
    if ({busy, done, agtb, aeqb, altb, nib_used} !== 9'b0) begin
      tests_failed++;
      $display("FAIL abort_state: busy=%b done=%b flags=%b nib=%0d expected all 0",
               busy, done, {agtb, aeqb, altb}, nib_used);
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", stray);
    end
    do_compare(32'h0000_0001, 32'h0000_0002, lat, bacc);
    tests_run++;
    if (lat !== 8 || {agtb, aeqb, altb, nib_used} !== {3'b001, 4'd8}) begin
      tests_failed++;
      $display("FAIL abort_recover: lat=%0d flags=%b nib=%0d expected lat=8 001 nib=8",
               lat, {agtb, aeqb, altb}, nib_used);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] av;
    logic [31:0] bv;
    logic [2:0]  exp_flags;
    int          exp_nib;
    int          sel;
    int          lat;
    logic        bacc;
    int          shown = 0;
    for (int n = 0; n < 1000; n++) begin
      av  = $urandom;
      sel = $urandom_range(0, 8);
      if (sel == 8) bv = $urandom;
      else          bv = av ^ ($urandom & ((32'h1 << (4 * sel)) - 32'h1));
      exp_flags = (av > bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
      exp_nib = 8;
      for (int i = 7; i >= 0; i--) begin
        if (av[4*i +: 4] != bv[4*i +: 4]) begin
          exp_nib = 8 - i;
          break;
        end
      end
      do_compare(av, bv, lat, bacc);
      tests_run++;
      if (lat !== exp_nib || {agtb, aeqb, altb} !== exp_flags ||
          nib_used !== CW'(exp_nib)) begin
        tests_failed++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random a=%h b=%h: lat=%0d flags=%b nib=%0d expected lat=%0d flags=%b nib=%0d",
                   av, bv, lat, {agtb, aeqb, altb}, nib_used, exp_nib, exp_flags, exp_nib);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_early_exit();
    test_late_diff();
    test_equal();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
